// File: rtl/memory_bus_arbiter.sv
// Two-requester memory bus arbiter with an in-order read tag FIFO that routes each returned beat to its issuer.
// Build option: define MEMORY_ARB_ROUND_ROBIN_EN for round-robin arbitration (default: fixed priority, M1 wins).
module memory_bus_arbiter #(
    parameter int P_TAG_DEPTH   = 4,
    parameter int P_TAG_DEPTH_N = 2
) (
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    input  logic        iM0_REQ,
    output logic        oM0_LOCK,
    input  logic [1:0]  iM0_ORDER,
    input  logic        iM0_RW,
    input  logic [31:0] iM0_ADDR,
    input  logic [31:0] iM0_DATA,
    output logic        oM0_VALID,
    input  logic        iM0_BUSY,
    output logic [63:0] oM0_DATA,
    input  logic        iM1_REQ,
    output logic        oM1_LOCK,
    input  logic [1:0]  iM1_ORDER,
    input  logic        iM1_RW,
    input  logic [31:0] iM1_ADDR,
    input  logic [31:0] iM1_DATA,
    output logic        oM1_VALID,
    input  logic        iM1_BUSY,
    output logic [63:0] oM1_DATA,
    output logic        oMEMORY_REQ,
    input  logic        iMEMORY_LOCK,
    output logic [1:0]  oMEMORY_ORDER,
    output logic        oMEMORY_RW,
    output logic [31:0] oMEMORY_ADDR,
    output logic [31:0] oMEMORY_DATA,
    input  logic        iMEMORY_VALID,
    output logic        oMEMORY_BUSY,
    input  logic [63:0] iMEMORY_DATA
);

    typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} arbState_t;

    localparam logic [P_TAG_DEPTH_N:0]   TagDepth = (P_TAG_DEPTH_N + 1)'(P_TAG_DEPTH);
    localparam logic [P_TAG_DEPTH_N:0]   CountOne = (P_TAG_DEPTH_N + 1)'(1);
    localparam logic [P_TAG_DEPTH_N-1:0] PtrOne   = (P_TAG_DEPTH_N)'(1);

    arbState_t                state, stateNext;
    logic                     grantReg;
    logic                     tagFifo [P_TAG_DEPTH];
    logic [P_TAG_DEPTH_N-1:0] wrPtr, rdPtr;
    logic [P_TAG_DEPTH_N:0]   tagCount;
    logic                     errorFlag;

    logic fifoEmpty, fifoFull, headOwner, headBusy, popTag, pushTag, strayValid;
    logic m0Eligible, m1Eligible, pick, curGrant, busActive, accept, selRw;

    assign fifoEmpty  = (tagCount == '0);
    assign fifoFull   = (tagCount == TagDepth);
    assign headOwner  = tagFifo[rdPtr];
    assign headBusy   = !fifoEmpty && (headOwner ? iM1_BUSY : iM0_BUSY);
    assign popTag     = iMEMORY_VALID && !fifoEmpty && !headBusy;
    assign strayValid = iMEMORY_VALID && fifoEmpty;

    // A read may enter a full FIFO only when a beat retires on the same edge.
    assign m0Eligible = iM0_REQ && (iM0_RW || !fifoFull || popTag);
    assign m1Eligible = iM1_REQ && (iM1_RW || !fifoFull || popTag);

`ifdef MEMORY_ARB_ROUND_ROBIN_EN
    logic prioPtr;
    assign pick = (m0Eligible && m1Eligible) ? prioPtr : m1Eligible;
`else
    assign pick = m1Eligible;
`endif

    // Grant selection and next state; a held command keeps its grant until memory takes it.
    always_comb begin
        stateNext = state;
        curGrant  = pick;
        busActive = m0Eligible || m1Eligible;
        if (state == ST_HOLD) begin
            curGrant  = grantReg;
            busActive = 1'b1;
        end
        selRw   = curGrant ? iM1_RW : iM0_RW;
        accept  = busActive && !iMEMORY_LOCK;
        pushTag = accept && !selRw;
        if (busActive) begin
            stateNext = iMEMORY_LOCK ? ST_HOLD : ST_IDLE;
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state     <= ST_IDLE;
            grantReg  <= 1'b0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            tagCount  <= '0;
            errorFlag <= 1'b0;
`ifdef MEMORY_ARB_ROUND_ROBIN_EN
            prioPtr   <= 1'b1;
`endif
        end else begin
            state <= stateNext;
            if (busActive) begin
                grantReg <= curGrant;
            end
            if (pushTag) begin
                wrPtr <= wrPtr + PtrOne;
            end
            if (popTag) begin
                rdPtr <= rdPtr + PtrOne;
            end
            case ({pushTag, popTag})
                2'b10:   tagCount <= tagCount + CountOne;
                2'b01:   tagCount <= tagCount - CountOne;
                default: tagCount <= tagCount;
            endcase
            if (strayValid) begin
                errorFlag <= 1'b1;
            end
`ifdef MEMORY_ARB_ROUND_ROBIN_EN
            if (accept) begin
                prioPtr <= ~curGrant;
            end
`endif
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (!iRESET_SYNC && pushTag) begin
            tagFifo[wrPtr] <= curGrant;
        end
    end

    // Bus and requester outputs; reset forces every control output to its idle value.
    always_comb begin
        oMEMORY_REQ   = 1'b0;
        oMEMORY_ORDER = 2'h3;
        oMEMORY_RW    = 1'b0;
        oMEMORY_ADDR  = '0;
        oMEMORY_DATA  = '0;
        oMEMORY_BUSY  = 1'b0;
        oM0_LOCK      = 1'b0;
        oM1_LOCK      = 1'b0;
        oM0_VALID     = 1'b0;
        oM1_VALID     = 1'b0;
        oM0_DATA      = iMEMORY_DATA;
        oM1_DATA      = iMEMORY_DATA;
        if (!iRESET_SYNC) begin
            if (busActive) begin
                oMEMORY_REQ   = 1'b1;
                oMEMORY_ORDER = curGrant ? iM1_ORDER : iM0_ORDER;
                oMEMORY_RW    = selRw;
                oMEMORY_ADDR  = curGrant ? iM1_ADDR : iM0_ADDR;
                oMEMORY_DATA  = curGrant ? iM1_DATA : iM0_DATA;
            end
            oMEMORY_BUSY = headBusy;
            oM0_LOCK     = iM0_REQ && !(busActive && !curGrant && !iMEMORY_LOCK);
            oM1_LOCK     = iM1_REQ && !(busActive && curGrant && !iMEMORY_LOCK);
            oM0_VALID    = iMEMORY_VALID && !fifoEmpty && !headOwner;
            oM1_VALID    = iMEMORY_VALID && !fifoEmpty && headOwner;
        end
    end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Self-checking bench for memory_bus_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_memory_bus_arbiter;

    localparam int DEPTH = 4;

    logic iCLOCK = 1'b0;
    always #5 iCLOCK = ~iCLOCK;

    logic        rst;
    logic        r0, rw0, b0, r1, rw1, b1;
    logic [1:0]  o0, o1;
    logic [31:0] a0, d0, a1, d1;
    logic        mlock, vld;
    logic [63:0] mdata;

    logic        oM0_LOCK, oM0_VALID, oM1_LOCK, oM1_VALID;
    logic [63:0] oM0_DATA, oM1_DATA;
    logic        oMEMORY_REQ, oMEMORY_RW, oMEMORY_BUSY;
    logic [1:0]  oMEMORY_ORDER;
    logic [31:0] oMEMORY_ADDR, oMEMORY_DATA;

    memory_bus_arbiter #(.P_TAG_DEPTH(DEPTH), .P_TAG_DEPTH_N(2)) dut (
        .iCLOCK(iCLOCK), .iRESET_SYNC(rst),
        .iM0_REQ(r0), .oM0_LOCK(oM0_LOCK), .iM0_ORDER(o0), .iM0_RW(rw0), .iM0_ADDR(a0), .iM0_DATA(d0),
        .oM0_VALID(oM0_VALID), .iM0_BUSY(b0), .oM0_DATA(oM0_DATA),
        .iM1_REQ(r1), .oM1_LOCK(oM1_LOCK), .iM1_ORDER(o1), .iM1_RW(rw1), .iM1_ADDR(a1), .iM1_DATA(d1),
        .oM1_VALID(oM1_VALID), .iM1_BUSY(b1), .oM1_DATA(oM1_DATA),
        .oMEMORY_REQ(oMEMORY_REQ), .iMEMORY_LOCK(mlock), .oMEMORY_ORDER(oMEMORY_ORDER), .oMEMORY_RW(oMEMORY_RW),
        .oMEMORY_ADDR(oMEMORY_ADDR), .oMEMORY_DATA(oMEMORY_DATA), .iMEMORY_VALID(vld),
        .oMEMORY_BUSY(oMEMORY_BUSY), .iMEMORY_DATA(mdata)
    );

    int passChecks = 0;
    int totalChecks = 0;

    // Reference model: queue of outstanding read owners, held-command flag, priority and error flag.
    int q[$];
    bit holding;
    int heldG;
    int prio;
    bit err;

    logic        eReq, eRw, eLock0, eLock1, eValid0, eValid1, eBusy;
    logic [1:0]  eOrder;
    logic [31:0] eAddr, eData;
    bit          active, popNow;
    int          g;

    task automatic checkEq(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalChecks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            passChecks++;
        end
    endtask

    task automatic computeExpected();
        bit full, headBusy, e0, e1;
        full     = (q.size() == DEPTH);
        headBusy = (q.size() > 0) && ((q[0] == 1) ? b1 : b0);
        popNow   = vld && (q.size() > 0) && !headBusy;
        e0 = r0 && (rw0 || !full || popNow);
        e1 = r1 && (rw1 || !full || popNow);
        if (holding) begin
            active = 1'b1;
            g      = heldG;
        end else begin
            active = e0 || e1;
            if (e0 && e1) begin
`ifdef MEMORY_ARB_ROUND_ROBIN_EN
                g = prio;
`else
                g = 1;
`endif
            end else begin
                g = e1 ? 1 : 0;
            end
        end
        eReq    = active;
        eOrder  = active ? ((g == 1) ? o1 : o0) : 2'h3;
        eRw     = active ? ((g == 1) ? rw1 : rw0) : 1'b0;
        eAddr   = active ? ((g == 1) ? a1 : a0) : 32'h0;
        eData   = active ? ((g == 1) ? d1 : d0) : 32'h0;
        eLock0  = r0 && !(active && g == 0 && !mlock);
        eLock1  = r1 && !(active && g == 1 && !mlock);
        eValid0 = vld && (q.size() > 0) && (q[0] == 0);
        eValid1 = vld && (q.size() > 0) && (q[0] == 1);
        eBusy   = headBusy;
        if (rst) begin
            eReq = 0; eOrder = 2'h3; eRw = 0; eAddr = 0; eData = 0;
            eLock0 = 0; eLock1 = 0; eValid0 = 0; eValid1 = 0; eBusy = 0;
        end
    endtask

    task automatic checkOutput();
        @(negedge iCLOCK);
        computeExpected();
        checkEq("memReq",   64'(oMEMORY_REQ),   64'(eReq));
        checkEq("memOrder", 64'(oMEMORY_ORDER), 64'(eOrder));
        checkEq("memRw",    64'(oMEMORY_RW),    64'(eRw));
        checkEq("memAddr",  64'(oMEMORY_ADDR),  64'(eAddr));
        checkEq("memData",  64'(oMEMORY_DATA),  64'(eData));
        checkEq("memBusy",  64'(oMEMORY_BUSY),  64'(eBusy));
        checkEq("m0Lock",   64'(oM0_LOCK),      64'(eLock0));
        checkEq("m1Lock",   64'(oM1_LOCK),      64'(eLock1));
        checkEq("m0Valid",  64'(oM0_VALID),     64'(eValid0));
        checkEq("m1Valid",  64'(oM1_VALID),     64'(eValid1));
        if (eValid0) checkEq("m0Data", oM0_DATA, mdata);
        if (eValid1) checkEq("m1Data", oM1_DATA, mdata);
        checkEq("errorFlag", 64'(dut.errorFlag), 64'(err));
    endtask

    task automatic tick();
        bit acc, rwSel;
        @(posedge iCLOCK);
        if (rst) begin
            q.delete();
            holding = 0;
            prio    = 1;
            err     = 0;
        end else begin
            rwSel = (g == 1) ? rw1 : rw0;
            acc   = active && !mlock;
            if (vld && q.size() == 0) err = 1;
            if (popNow) void'(q.pop_front());
            if (acc && !rwSel) q.push_back(g);
            holding = active && mlock;
            if (holding) heldG = g;
            if (acc) prio = 1 - g;
        end
        #1;
    endtask

    task automatic idleInputs();
        r0 = 0; rw0 = 0; o0 = 2'h3; a0 = 0; d0 = 0; b0 = 0;
        r1 = 0; rw1 = 0; o1 = 2'h3; a1 = 0; d1 = 0; b1 = 0;
        mlock = 0; vld = 0; mdata = 0;
    endtask

    task automatic setReq(input int m, input bit r, input bit rw, input logic [31:0] addr);
        if (m == 0) begin
            r0 = r; rw0 = rw; o0 = 2'b10; a0 = addr; d0 = addr ^ 32'hDEAD_BEEF;
        end else begin
            r1 = r; rw1 = rw; o1 = 2'b10; a1 = addr; d1 = addr ^ 32'hCAFE_F00D;
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            idleInputs();
            vld = 1;
            mdata = {$urandom, $urandom};
            checkOutput();
            tick();
        end
        idleInputs();
    endtask

    task automatic applyStimulus();
        if (!(r0 && eLock0)) begin
            r0 = ($urandom_range(0, 2) != 0); rw0 = ($urandom_range(0, 3) == 0);
            o0 = 2'($urandom_range(0, 3)); a0 = $urandom; d0 = $urandom;
        end
        if (!(r1 && eLock1)) begin
            r1 = ($urandom_range(0, 2) != 0); rw1 = ($urandom_range(0, 3) == 0);
            o1 = 2'($urandom_range(0, 3)); a1 = $urandom; d1 = $urandom;
        end
        mlock = ($urandom_range(0, 3) == 0);
        b0    = ($urandom_range(0, 3) == 0);
        b1    = ($urandom_range(0, 3) == 0);
        vld   = (q.size() > 0) && ($urandom_range(0, 1) == 1);
        mdata = {$urandom, $urandom};
    endtask

    initial begin
        int own4[4];
        int v1Pat[4];
        own4  = '{0, 1, 1, 0};
        v1Pat = '{1, 0, 1, 1};
        holding = 0; heldG = 0; prio = 1; err = 0; g = 0;
        idleInputs();
        rst = 1;
        #1;
        checkOutput(); tick();
        checkOutput(); tick();
        rst = 0;
        checkOutput();
        checkEq("rstOrder", 64'(oMEMORY_ORDER), 64'h3);
        checkEq("rstReq",   64'(oMEMORY_REQ),   64'h0);
        tick();

        // Single M0 read and its returned beat
        setReq(0, 1, 0, 32'h100);
        checkOutput();
        checkEq("t1Req",   64'(oMEMORY_REQ),  64'h1);
        checkEq("t1Addr",  64'(oMEMORY_ADDR), 64'h100);
        checkEq("t1Lock0", 64'(oM0_LOCK),     64'h0);
        tick();
        idleInputs();
        vld = 1; mdata = 64'hA5A5_A5A5_A5A5_A5A5;
        checkOutput();
        checkEq("t1Valid0", 64'(oM0_VALID), 64'h1);
        checkEq("t1Valid1", 64'(oM1_VALID), 64'h0);
        checkEq("t1Data",   oM0_DATA,       64'hA5A5_A5A5_A5A5_A5A5);
        tick();
        idleInputs();

        // Simultaneous reads: M1 holds priority at this point in both arbitration modes
        setReq(0, 1, 0, 32'h200); setReq(1, 1, 0, 32'h204);
        checkOutput();
        checkEq("t2Addr",  64'(oMEMORY_ADDR), 64'h204);
        checkEq("t2Lock0", 64'(oM0_LOCK),     64'h1);
        checkEq("t2Lock1", 64'(oM1_LOCK),     64'h0);
        tick();
        setReq(1, 0, 0, 0);
        checkOutput();
        checkEq("t2Addr2",  64'(oMEMORY_ADDR), 64'h200);
        checkEq("t2Lock0b", 64'(oM0_LOCK),     64'h0);
        tick();
        drain(2);
        for (int p = 0; p < 4; p++) begin
            setReq(0, 1, 0, 32'h280 + 32'(p * 8)); setReq(1, 1, 0, 32'h284 + 32'(p * 8));
            checkOutput(); tick();
            setReq(g, 0, 0, 0);
            checkOutput(); tick();
            drain(2);
        end

        // Memory stall holds M0's command while M1 waits
        setReq(0, 1, 0, 32'h300); mlock = 1;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) setReq(1, 1, 0, 32'h304);
            checkOutput();
            checkEq("t3Addr", 64'(oMEMORY_ADDR), 64'h300);
            if (i >= 1) checkEq("t3Lock1", 64'(oM1_LOCK), 64'h1);
            tick();
        end
        mlock = 0;
        checkOutput();
        checkEq("t3AddrAcc", 64'(oMEMORY_ADDR), 64'h300);
        checkEq("t3Lock0",   64'(oM0_LOCK),     64'h0);
        checkEq("t3Lock1b",  64'(oM1_LOCK),     64'h1);
        tick();
        setReq(0, 0, 0, 0);
        checkOutput();
        checkEq("t3Addr304", 64'(oMEMORY_ADDR), 64'h304);
        tick();
        drain(2);

        // Fill the tag FIFO, then a read is blocked while a write still goes through
        for (int i = 0; i < 4; i++) begin
            idleInputs();
            setReq(own4[i], 1, 0, 32'h400 + 32'(i * 4));
            checkOutput();
            checkEq("t4Lock", 64'((own4[i] == 0) ? oM0_LOCK : oM1_LOCK), 64'h0);
            tick();
        end
        idleInputs();
        setReq(0, 1, 0, 32'h500);
        checkOutput();
        checkEq("t4FullLock", 64'(oM0_LOCK),    64'h1);
        checkEq("t4FullReq",  64'(oMEMORY_REQ), 64'h0);
        tick();
        setReq(0, 1, 1, 32'h504);
        checkOutput();
        checkEq("t4WrReq",  64'(oMEMORY_REQ), 64'h1);
        checkEq("t4WrRw",   64'(oMEMORY_RW),  64'h1);
        checkEq("t4WrLock", 64'(oM0_LOCK),    64'h0);
        tick();
        idleInputs();
        for (int i = 0; i < 4; i++) begin
            vld = 1; mdata = {32'h4444_0000, 32'(i)};
            checkOutput();
            checkEq("t4Route0", 64'(oM0_VALID), 64'(own4[i] == 0));
            checkEq("t4Route1", 64'(oM1_VALID), 64'(own4[i] == 1));
            tick();
        end
        idleInputs();

        // Full FIFO with a read accepted on the same edge a beat retires
        for (int i = 0; i < 4; i++) begin
            idleInputs();
            setReq(i % 2, 1, 0, 32'h600 + 32'(i * 4));
            checkOutput(); tick();
        end
        idleInputs();
        setReq(1, 1, 0, 32'h640); vld = 1; mdata = 64'h5555;
        checkOutput();
        checkEq("t5Lock1",  64'(oM1_LOCK),  64'h0);
        checkEq("t5Valid0", 64'(oM0_VALID), 64'h1);
        tick();
        idleInputs();
        checkOutput();
        checkEq("t5Count", 64'(dut.tagCount), 64'h4);
        tick();
        for (int i = 0; i < 4; i++) begin
            vld = 1; mdata = {32'h5555_0000, 32'(i)};
            checkOutput();
            checkEq("t5Route1", 64'(oM1_VALID), 64'(v1Pat[i]));
            tick();
        end
        idleInputs();

        // Reset during a stalled command with two reads outstanding
        setReq(0, 1, 0, 32'h700); checkOutput(); tick();
        idleInputs(); setReq(1, 1, 0, 32'h704); checkOutput(); tick();
        idleInputs(); setReq(0, 1, 0, 32'h708); mlock = 1; checkOutput(); tick();
        rst = 1;
        checkOutput();
        checkEq("t6RstReq", 64'(oMEMORY_REQ), 64'h0);
        tick();
        rst = 0; idleInputs();
        checkOutput();
        checkEq("t6Order", 64'(oMEMORY_ORDER), 64'h3);
        checkEq("t6Addr",  64'(oMEMORY_ADDR),  64'h0);
        checkEq("t6Busy",  64'(oMEMORY_BUSY),  64'h0);
        tick();
        vld = 1; mdata = 64'h6666;
        checkOutput();
        checkEq("t6NoValid0", 64'(oM0_VALID), 64'h0);
        checkEq("t6NoValid1", 64'(oM1_VALID), 64'h0);
        tick();
        idleInputs();
        checkOutput();
        checkEq("t6Err", 64'(dut.errorFlag), 64'h1);
        tick();
        rst = 1; checkOutput(); tick(); rst = 0;

        // Randomized traffic checked cycle by cycle against the model
        for (int c = 0; c < 2000; c++) begin
            applyStimulus();
            checkOutput();
            tick();
        end

        $display("%0d/%0d checks passed", passChecks, totalChecks);
        $finish;
    end

endmodule
